// File: rtl/regfile_mp.sv
// Multi-read-port register file with one synchronous write port, optional write bypass,
// hardwired zero entry and a clear sequencer that zeroes every entry after reset or on request.
module regfile_mp #(
    parameter int WIDTH     = 32,
    parameter int ADDR_BITS = 5,
    parameter int NREAD     = 2,
    parameter int BYPASS    = 1,
    parameter int ZERO_REG  = 1
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       f_regwrite,
    input  logic [ADDR_BITS-1:0]       writereg,
    input  logic [WIDTH-1:0]           writedata,
    input  logic [NREAD*ADDR_BITS-1:0] raddr,
    output logic [NREAD*WIDTH-1:0]     rdata,
    input  logic                       clear_req,
    output logic                       busy,
    output logic                       wr_dropped
);

    localparam int DEPTH = 1 << ADDR_BITS;
    localparam logic [ADDR_BITS-1:0] LAST_PTR = ADDR_BITS'(DEPTH - 1);
    localparam bit ZERO_EN   = (ZERO_REG != 0);
    localparam bit BYPASS_EN = (BYPASS != 0);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_e;

    state_e                 state_q, state_d;
    logic [ADDR_BITS-1:0]   clr_ptr_q, clr_ptr_d;
    logic                   wr_dropped_q, wr_dropped_d;
    logic                   mem_we_d;
    logic [ADDR_BITS-1:0]   mem_waddr_d;
    logic [WIDTH-1:0]       mem_wdata_d;
    logic [WIDTH-1:0]       mem_q [DEPTH];

    // State register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= ST_CLEAR;
            clr_ptr_q    <= '0;
            wr_dropped_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            clr_ptr_q    <= clr_ptr_d;
            wr_dropped_q <= wr_dropped_d;
        end
    end

    // Storage is not reset; the sweep is what initialises it.
    always_ff @(posedge clk) begin
        if (reset_n && mem_we_d) begin
            mem_q[mem_waddr_d] <= mem_wdata_d;
        end
    end

    // Next-state and write-port steering
    always_comb begin
        state_d      = state_q;
        clr_ptr_d    = clr_ptr_q;
        wr_dropped_d = 1'b0;
        mem_we_d     = 1'b0;
        mem_waddr_d  = writereg;
        mem_wdata_d  = writedata;
        case (state_q)
            ST_CLEAR: begin
                mem_we_d     = 1'b1;
                mem_waddr_d  = clr_ptr_q;
                mem_wdata_d  = '0;
                clr_ptr_d    = clr_ptr_q + 1'b1;
                wr_dropped_d = f_regwrite;
                if (clr_ptr_q == LAST_PTR) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                if (f_regwrite && !(ZERO_EN && (writereg == '0))) begin
                    mem_we_d = 1'b1;
                end
                if (clear_req) begin
                    state_d = ST_CLEAR;
                end
            end
        endcase
    end

    // Outputs: zero has priority over bypass, bypass over stored contents
    always_comb begin
        busy       = (state_q == ST_CLEAR);
        wr_dropped = wr_dropped_q;
        rdata      = '0;
        for (int i = 0; i < NREAD; i++) begin
            if (busy) begin
                rdata[i*WIDTH +: WIDTH] = '0;
            end else if (ZERO_EN && (raddr[i*ADDR_BITS +: ADDR_BITS] == '0)) begin
                rdata[i*WIDTH +: WIDTH] = '0;
            end else if (BYPASS_EN && f_regwrite &&
                         (raddr[i*ADDR_BITS +: ADDR_BITS] == writereg)) begin
                rdata[i*WIDTH +: WIDTH] = writedata;
            end else begin
                rdata[i*WIDTH +: WIDTH] = mem_q[raddr[i*ADDR_BITS +: ADDR_BITS]];
            end
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: instance a (3 ports, bypass, zero reg) and
// instance b (1 port, no bypass, no zero reg) share clock, reset and write port.
module tb_regfile_mp;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        f_regwrite;
    logic [4:0]  writereg;
    logic [31:0] writedata;
    logic        clear_req;
    logic [14:0] raddr_a;
    logic [95:0] rdata_a;
    logic        busy_a, wr_dropped_a;
    logic [4:0]  raddr_b;
    logic [31:0] rdata_b;
    logic        busy_b, wr_dropped_b;

    int vec_cnt = 0;
    int err_cnt = 0;

    always #5 clk = ~clk;

    regfile_mp #(.WIDTH(32), .ADDR_BITS(5), .NREAD(3), .BYPASS(1), .ZERO_REG(1)) dut_a (
        .clk(clk), .reset_n(reset_n), .f_regwrite(f_regwrite), .writereg(writereg),
        .writedata(writedata), .raddr(raddr_a), .rdata(rdata_a), .clear_req(clear_req),
        .busy(busy_a), .wr_dropped(wr_dropped_a)
    );

    regfile_mp #(.WIDTH(32), .ADDR_BITS(5), .NREAD(1), .BYPASS(0), .ZERO_REG(0)) dut_b (
        .clk(clk), .reset_n(reset_n), .f_regwrite(f_regwrite), .writereg(writereg),
        .writedata(writedata), .raddr(raddr_b), .rdata(rdata_b), .clear_req(clear_req),
        .busy(busy_b), .wr_dropped(wr_dropped_b)
    );

    // Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        int cnt;
        reset_n = 1'b0; f_regwrite = 1'b0; writereg = '0; writedata = '0;
        clear_req = 1'b0; raddr_a = '0; raddr_b = '0;
        tick(); tick();
        #1;
        vec_cnt++;
        if (busy_a !== 1'b1 || wr_dropped_a !== 1'b0) begin
            err_cnt++; $display("FAIL reset_state: busy=%b wr_dropped=%b want 1 0", busy_a, wr_dropped_a);
        end
        reset_n = 1'b1;
        cnt = 0;
        while (busy_a === 1'b1 && cnt < 40) begin
            tick(); cnt++;
        end
        vec_cnt++;
        if (cnt !== 32) begin
            err_cnt++; $display("FAIL reset_sweep_len: busy cycles=%0d want 32", cnt);
        end
        vec_cnt++;
        if (busy_b !== 1'b0) begin
            err_cnt++; $display("FAIL reset_sweep_b: busy=%b want 0", busy_b);
        end
        for (int a = 0; a < 32; a++) begin
            raddr_a = {3{5'(a)}}; raddr_b = 5'(a);
            #1;
            vec_cnt++;
            if (rdata_a !== 96'h0 || rdata_b !== 32'h0) begin
                err_cnt++; $display("FAIL reset_contents: addr=%0d a=%h b=%h want 0", a, rdata_a, rdata_b);
            end
        end
    endtask

    task automatic test_write_bypass();
        f_regwrite = 1'b1; writereg = 5'd7; writedata = 32'hDEADBEEF;
        raddr_a = {5'd0, 5'd0, 5'd7}; raddr_b = 5'd7;
        #1;
        vec_cnt++;
        if (rdata_a[31:0] !== 32'hDEADBEEF) begin
            err_cnt++; $display("FAIL bypass_same_cycle: got %h want deadbeef", rdata_a[31:0]);
        end
        vec_cnt++;
        if (rdata_b !== 32'h0) begin
            err_cnt++; $display("FAIL nobypass_same_cycle: got %h want 0", rdata_b);
        end
        tick();
        f_regwrite = 1'b0; writedata = 32'h0;
        #1;
        vec_cnt++;
        if (rdata_a[31:0] !== 32'hDEADBEEF || rdata_b !== 32'hDEADBEEF) begin
            err_cnt++; $display("FAIL write_next_cycle: a=%h b=%h want deadbeef", rdata_a[31:0], rdata_b);
        end
    endtask

    task automatic test_zero_reg();
        f_regwrite = 1'b1; writereg = 5'd0; writedata = 32'h12345678;
        raddr_a = '0; raddr_b = 5'd0;
        #1;
        vec_cnt++;
        if (rdata_a !== 96'h0) begin
            err_cnt++; $display("FAIL zero_reg_write_cycle: got %h want 0", rdata_a);
        end
        vec_cnt++;
        if (rdata_b !== 32'h0) begin
            err_cnt++; $display("FAIL nozero_write_cycle: got %h want 0", rdata_b);
        end
        tick();
        f_regwrite = 1'b0;
        #1;
        vec_cnt++;
        if (rdata_a !== 96'h0 || wr_dropped_a !== 1'b0) begin
            err_cnt++; $display("FAIL zero_reg_after: rdata=%h wr_dropped=%b want 0 0", rdata_a, wr_dropped_a);
        end
        vec_cnt++;
        if (rdata_b !== 32'h12345678) begin
            err_cnt++; $display("FAIL nozero_after: got %h want 12345678", rdata_b);
        end
    endtask

    task automatic test_multi_port();
        f_regwrite = 1'b1;
        writereg = 5'd1; writedata = 32'h11; tick();
        writereg = 5'd2; writedata = 32'h22; tick();
        writereg = 5'd3; writedata = 32'h33; tick();
        f_regwrite = 1'b0;
        raddr_a = {5'd3, 5'd2, 5'd1}; raddr_b = 5'd3;
        #1;
        vec_cnt++;
        if (rdata_a !== {32'h33, 32'h22, 32'h11}) begin
            err_cnt++; $display("FAIL multi_port_distinct: got %h want 33/22/11", rdata_a);
        end
        vec_cnt++;
        if (rdata_b !== 32'h33) begin
            err_cnt++; $display("FAIL multi_port_b: got %h want 33", rdata_b);
        end
        raddr_a = {5'd2, 5'd2, 5'd2};
        #1;
        vec_cnt++;
        if (rdata_a !== {3{32'h22}}) begin
            err_cnt++; $display("FAIL multi_port_shared: got %h want 22 x3", rdata_a);
        end
    endtask

    task automatic test_clear_collide();
        int cnt;
        int pulses;
        f_regwrite = 1'b1; writereg = 5'd5; writedata = 32'hAA; tick();
        writereg = 5'd4; writedata = 32'h44; tick();
        f_regwrite = 1'b0;
        raddr_a = {5'd9, 5'd5, 5'd4};
        #1;
        vec_cnt++;
        if (rdata_a !== {32'h0, 32'hAA, 32'h44}) begin
            err_cnt++; $display("FAIL pre_clear_contents: got %h want 0/aa/44", rdata_a);
        end
        clear_req = 1'b1; f_regwrite = 1'b1; writereg = 5'd9; writedata = 32'h55;
        #1;
        vec_cnt++;
        if (busy_a !== 1'b0) begin
            err_cnt++; $display("FAIL clear_req_cycle_busy: got %b want 0", busy_a);
        end
        tick();
        clear_req = 1'b0; f_regwrite = 1'b0;
        #1;
        vec_cnt++;
        if (busy_a !== 1'b1 || wr_dropped_a !== 1'b0 || rdata_a !== 96'h0) begin
            err_cnt++; $display("FAIL clear_start: busy=%b wr_dropped=%b rdata=%h want 1 0 0", busy_a, wr_dropped_a, rdata_a);
        end
        f_regwrite = 1'b1; writereg = 5'd4; writedata = 32'h77;
        tick();
        f_regwrite = 1'b0;
        #1;
        vec_cnt++;
        if (wr_dropped_a !== 1'b1 || wr_dropped_b !== 1'b1) begin
            err_cnt++; $display("FAIL wr_dropped_pulse: a=%b b=%b want 1 1", wr_dropped_a, wr_dropped_b);
        end
        cnt = 1; pulses = 0;
        while (busy_a === 1'b1 && cnt < 40) begin
            clear_req = (cnt == 20);
            tick(); cnt++;
            if (wr_dropped_a === 1'b1) pulses++;
        end
        clear_req = 1'b0;
        vec_cnt++;
        if (cnt !== 32) begin
            err_cnt++; $display("FAIL clear_req_sweep_len: busy cycles=%0d want 32", cnt);
        end
        vec_cnt++;
        if (pulses !== 0) begin
            err_cnt++; $display("FAIL wr_dropped_extra: extra pulses=%0d want 0", pulses);
        end
        raddr_a = {5'd9, 5'd5, 5'd4}; raddr_b = 5'd9;
        #1;
        vec_cnt++;
        if (rdata_a !== 96'h0 || rdata_b !== 32'h0) begin
            err_cnt++; $display("FAIL post_clear_contents: a=%h b=%h want 0", rdata_a, rdata_b);
        end
    endtask

    task automatic test_reset_mid_sweep();
        int cnt;
        f_regwrite = 1'b1;
        writereg = 5'd10; writedata = 32'h99; tick();
        writereg = 5'd31; writedata = 32'hCAFE; tick();
        f_regwrite = 1'b0;
        clear_req = 1'b1; tick();
        clear_req = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        #1;
        vec_cnt++;
        if (busy_a !== 1'b1) begin
            err_cnt++; $display("FAIL mid_reset_busy: got %b want 1", busy_a);
        end
        cnt = 0;
        while (busy_a === 1'b1 && cnt < 40) begin
            tick(); cnt++;
        end
        vec_cnt++;
        if (cnt !== 32) begin
            err_cnt++; $display("FAIL mid_reset_sweep_len: busy cycles=%0d want 32", cnt);
        end
        for (int a = 0; a < 32; a++) begin
            raddr_a = {3{5'(a)}}; raddr_b = 5'(a);
            #1;
            vec_cnt++;
            if (rdata_a !== 96'h0 || rdata_b !== 32'h0) begin
                err_cnt++; $display("FAIL mid_reset_contents: addr=%0d a=%h b=%h want 0", a, rdata_a, rdata_b);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation still running at %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_write_bypass();
        test_zero_reg();
        test_multi_port();
        test_clear_collide();
        test_reset_mid_sweep();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-read-port register file for the MIPS-style datapath, successor to the fixed 32x32 two-read-port file. It provides NREAD combinational read ports, one synchronous write port, an optional write-to-read bypass, and a hardwired zero register. A hardware clear sequencer zeroes every entry after reset or on request, so no memory-init file is needed. It sits between decode (read addresses) and writeback (write port).

## Interface
- WIDTH, 32, data bits per register
- ADDR_BITS, 5, address width; DEPTH = 2^ADDR_BITS entries
- NREAD, 2, number of read ports (1..4)
- BYPASS, 1, 1 = a same-cycle write is forwarded to matching read ports; 0 = reads return stored contents only
- ZERO_REG, 1, 1 = entry 0 always reads 0 and ignores writes
- clk  in  1  clock; all state updates on rising edge
- reset_n  in  1  synchronous, active-low reset
- f_regwrite  in  1  write enable
- writereg  in  ADDR_BITS  write address
- writedata  in  WIDTH  write data
- raddr  in  NREAD*ADDR_BITS  read addresses; port i at bits [i*ADDR_BITS +: ADDR_BITS]
- rdata  out  NREAD*WIDTH  read data; port i at bits [i*WIDTH +: WIDTH]
- clear_req  in  1  single-cycle pulse requesting a full clear
- busy  out  1  high while the clear sequencer runs
- wr_dropped  out  1  registered; pulses 1 cycle after a write arrives while busy

## Operation
- FSM states are CLEAR and IDLE. An internal clear pointer clr_ptr is ADDR_BITS wide.
- Reset: with reset_n=0 at a clock edge, state=CLEAR, clr_ptr=0, wr_dropped=0. busy is combinational (state==CLEAR), so it is 1 during and after reset.
- CLEAR: each cycle writes 0 to entry clr_ptr and increments clr_ptr. When clr_ptr==DEPTH-1, the state moves to IDLE on that edge and clr_ptr wraps to 0. This takes exactly DEPTH cycles.
- In CLEAR, f_regwrite is ignored and the entry is not written. wr_dropped is set for 1 cycle. Every rdata port reads 0.
- In CLEAR, clear_req is ignored; the sweep does not restart.
- IDLE with f_regwrite=1: mem[writereg] <= writedata at the edge. If ZERO_REG=1 and writereg==0, the write is discarded, with no wr_dropped pulse.
- IDLE with clear_req=1: the state moves to CLEAR on that edge. A write in the same cycle is committed, then wiped by the sweep.
- Read port i: rdata_i = 0 in each of these cases:
  - state==CLEAR
  - ZERO_REG and raddr_i==0
- Otherwise, rdata_i = writedata if BYPASS and f_regwrite and raddr_i==writereg.
- In all other cases, rdata_i = mem[raddr_i].
- All read ports are independent. Any number of them may share an address.
- Reset mid-sweep restarts the sweep at clr_ptr=0.

## Timing
- Read latency is 0 cycles: rdata is combinational from raddr, state and mem, plus the bypass inputs.
- Write latency is 1 cycle. With BYPASS=0, a read of the written address shows new data the cycle after the write. With BYPASS=1, it shows new data the same cycle.
- Clear from reset release: busy falls after DEPTH rising edges with reset_n=1. For DEPTH=32, busy=1 for edges 1..32 and is 0 after edge 32.
- Clear from clear_req: busy rises the cycle after the clear_req edge, stays high for DEPTH cycles, then falls.
- wr_dropped is registered: high the cycle after the dropped write, otherwise 0.
- One write per cycle. No read/write port conflicts exist; a read port never stalls.

## Test plan
- Reset then sweep, defaults: hold reset_n=0 for 2 cycles, then release. Required: busy=1 for exactly 32 cycles, then 0. All ports read 0 for addresses 0..31 afterward.
- Write then read, BYPASS=1: write 0xDEADBEEF to reg 7 with raddr0=7. Required: rdata0=0xDEADBEEF in the same cycle and in following cycles. Repeat with BYPASS=0: rdata0 holds the old value (0) in the write cycle and reads 0xDEADBEEF the next cycle.
- Zero register: write 0x12345678 to reg 0. Required: all ports read 0 for address 0, including in the write cycle, and wr_dropped=0. With ZERO_REG=0, reg 0 reads 0x12345678 the next cycle.
- Multi-port (NREAD=3): write regs 1/2/3 = 0x11/0x22/0x33, then set raddr={3,2,1}. Required: rdata={0x33,0x22,0x11}. Then set all three raddr to 2. Required: all ports read 0x22.
- Clear request with a colliding write: in IDLE with reg 5=0xAA, assert clear_req and write reg 9=0x55 in the same cycle. Then attempt a write to reg 4 during busy. Required:
  - busy is high for 32 cycles.
  - wr_dropped pulses once, 1 cycle after the reg-4 write attempt.
  - After busy falls, regs 4, 5 and 9 read 0.
- Reset mid-sweep: assert clear_req, then pulse reset_n=0 on the 10th busy cycle. Required: busy stays high for a full 32 cycles after reset release, and all entries read 0.
